min_max_pwm: RTL
================

MIN_MAX_PWM -- requirements
Module: min_max_pwm

Interface
REQ-001 Parameter VALSIZE, default 4: bit width of min/max/value; LED bar width is 2**VALSIZE.
REQ-002 Parameter PWMSIZE, default 4: bit width of PWM counter and duty input.
REQ-003 Parameter STEPDIV, default 4: clock cycles per ramp step, legal range >= 1.
REQ-004 clk_i  in  1: single clock; all state updates on rising edge.
REQ-005 rst_i  in  1: asynchronous, active-high reset.
REQ-006 com_i  in  2: mode (00 normal, 01 linear, 10 all off, 11 all on).
REQ-007 min_i  in  VALSIZE: lower bound of bar (normal mode).
REQ-008 max_i  in  VALSIZE: upper bound of bar (normal mode).
REQ-009 val_i  in  VALSIZE: target bar value.
REQ-010 duty_i  in  PWMSIZE: dim-segment intensity.
REQ-011 load_i  in  1: configuration valid strobe.
REQ-012 ready_o  out  1: block accepts a configuration.
REQ-013 leds_o  out  2**VALSIZE: registered LED bar.

Function
REQ-014 Config SHALL be captured (com, min, max, duty and target <= val_i) only on an edge where load_i=1 and ready_o=1; load_i while ready_o=0 SHALL be ignored, with no state change.
REQ-015 Internal registers: com_r, min_r, max_r, duty_r, target, disp (displayed value, VALSIZE bits), pwm_cnt (PWMSIZE), step_cnt, state {IDLE, RAMP}.
REQ-016 IDLE: ready_o=1; on capture, if val_i == disp stay IDLE, else go RAMP with step_cnt cleared.
REQ-017 RAMP: ready_o=0; step_cnt counts 0..STEPDIV-1; on the edge where step_cnt = STEPDIV-1, disp moves one toward target (+1 or -1) and step_cnt returns to 0.
REQ-018 RAMP -> IDLE on the edge where disp becomes equal to target; ready_o=1 from the following cycle.
REQ-019 disp SHALL never wrap; it moves by exactly 1 per step and stops at target (0 and 2**VALSIZE-1 are reachable endpoints).
REQ-020 pwm_cnt is free-running, incrementing every cycle and wrapping from 2**PWMSIZE-1 to 0; pwm_on = (pwm_cnt < duty_r); duty_r=0 gives always off.
REQ-021 leds_o SHALL be registered, computed from the register values present before the edge (one cycle latency after any register change).
REQ-022 Mode 00: if min_r <= disp <= max_r, bits min_r..disp = 1, bits disp+1..max_r = pwm_on, and all other bits = 0; otherwise all bits = 0.
REQ-023 Mode 01: bits 0..disp = 1; all others 0 (min_r, max_r and duty_r ignored).
REQ-024 Mode 10: all bits 0.
REQ-025 Mode 11: all bits 1.
REQ-026 Mode, bounds and duty SHALL take effect immediately on capture; only the value ramps.
REQ-027 min_r > max_r in mode 00: all bits 0 for the whole duration, including during a ramp.

Reset
REQ-028 rst_i=1 SHALL immediately set the following: state=IDLE, ready_o=1, leds_o=0, com_r=10, min_r=max_r=target=disp=0, duty_r=0, pwm_cnt=0, step_cnt=0.
REQ-029 Reset mid-RAMP SHALL abort the ramp with no residual state; the first capture after release is accepted normally.

Verification (VALSIZE=4, PWMSIZE=4, STEPDIV=4)
REQ-030 Reset scenario: assert rst_i asynchronously between clock edges -> leds_o=0x0000 and ready_o=1 with no clock edge.
REQ-031 All-on scenario: load com=11 from reset state -> ready_o stays 1; leds_o=0xFFFF one cycle after the capture edge.
REQ-032 Normal-ramp scenario: load com=00, min=3, max=12, val=8, duty=8 from disp=0.
  - ready_o=0 for 32 cycles, with disp incrementing every 4 cycles.
  - Then leds_o bits 3..8 = 1, and bits 9..12 high for exactly 8 of every 16 cycles.
  - All other bits = 0.
REQ-033 Linear-boundary scenario: load com=01, val=15 -> disp ramps to 15 without wrap; leds_o=0xFFFF; a subsequent load of val=0 ramps down to leds_o=0x0001.
REQ-034 Invalid-config scenario: load com=00, min=10, max=5, val=7 -> leds_o=0x0000 throughout the ramp and after it.
REQ-035 Handshake/reset scenario:
  - Pulse load_i with val=2 while ready_o=0 -> ignored, and the ramp target is unchanged.
  - Assert rst_i mid-RAMP -> leds_o=0, ready_o=1, disp=0.

Source files
------------

// File: rtl/min_max_pwm.sv
// rtl/min_max_pwm.sv - LED bar with min/max window, PWM-dimmed segment and ramped value
module min_max_pwm #(
    parameter int VALSIZE = 4,
    parameter int PWMSIZE = 4,
    parameter int STEPDIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              com_i,
    input  logic [VALSIZE-1:0]      min_i,
    input  logic [VALSIZE-1:0]      max_i,
    input  logic [VALSIZE-1:0]      val_i,
    input  logic [PWMSIZE-1:0]      duty_i,
    input  logic                    load_i,
    output logic                    ready_o,
    output logic [2**VALSIZE-1:0]   leds_o
);

    localparam int NLEDS = 2**VALSIZE;
    localparam int SW = (STEPDIV > 1) ? $clog2(STEPDIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPDIV - 1);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t state, state_next;

    logic [1:0]          com_r;
    logic [VALSIZE-1:0]  min_r;
    logic [VALSIZE-1:0]  max_r;
    logic [PWMSIZE-1:0]  duty_r;
    logic [VALSIZE-1:0]  target;
    logic [VALSIZE-1:0]  disp;
    logic [PWMSIZE-1:0]  pwm_cnt;
    logic [SW-1:0]       step_cnt;

    logic                capture;
    logic                step_done;
    logic [VALSIZE-1:0]  disp_step;
    logic                pwm_on;
    logic                in_range;
    logic [NLEDS-1:0]    leds_next;

    // A configuration is only taken while idle; loads during a ramp are dropped.
    assign ready_o   = (state == IDLE);
    assign capture   = load_i && ready_o;
    assign step_done = (state == RAMP) && (step_cnt == STEP_LAST);
    // In RAMP disp never equals target, so this step always moves toward it and cannot wrap.
    assign disp_step = (disp < target) ? disp + VALSIZE'(1) : disp - VALSIZE'(1);
    assign pwm_on    = (pwm_cnt < duty_r);
    assign in_range  = (min_r <= disp) && (disp <= max_r);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start a ramp when a new value differs, stop once disp lands on target.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (capture && (val_i != disp)) state_next = RAMP;
            RAMP: if (step_done && (disp_step == target)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Configuration capture; mode, bounds and duty apply at once, only disp ramps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            com_r  <= 2'b10;
            min_r  <= '0;
            max_r  <= '0;
            duty_r <= '0;
            target <= '0;
        end else if (capture) begin
            com_r  <= com_i;
            min_r  <= min_i;
            max_r  <= max_i;
            duty_r <= duty_i;
            target <= val_i;
        end
    end

    // Ramp divider and displayed value: one unit step every STEPDIV cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_cnt <= '0;
            disp     <= '0;
        end else if (capture) begin
            step_cnt <= '0;
        end else if (state == RAMP) begin
            if (step_done) begin
                step_cnt <= '0;
                disp     <= disp_step;
            end else begin
                step_cnt <= step_cnt + SW'(1);
            end
        end
    end

    // Free-running PWM phase counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWMSIZE'(1);
        end
    end

    // LED pattern from current register values; registered below.
    always_comb begin
        leds_next = '0;
        case (com_r)
            2'b00: begin
                if (in_range) begin
                    for (int i = 0; i < NLEDS; i++) begin
                        if ((VALSIZE'(i) >= min_r) && (VALSIZE'(i) <= disp)) begin
                            leds_next[i] = 1'b1;
                        end else if ((VALSIZE'(i) > disp) && (VALSIZE'(i) <= max_r)) begin
                            leds_next[i] = pwm_on;
                        end
                    end
                end
            end
            2'b01: begin
                for (int i = 0; i < NLEDS; i++) begin
                    leds_next[i] = (VALSIZE'(i) <= disp);
                end
            end
            2'b10: leds_next = '0;
            default: leds_next = '1;
        endcase
    end

    // Output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            leds_o <= '0;
        end else begin
            leds_o <= leds_next;
        end
    end

endmodule
